// File: rtl/stream_cipher_arbiter_if.sv
// Bundle between the two byte requesters, the channel arbiter and the shared
// stream_cipher instance. The arbiter uses "master"; requesters plus cipher use "slave".
interface stream_cipher_arbiter_if;
  // requester side
  logic [1:0][7:0] ch_key;
  logic [1:0]      ch_key_in;
  logic [1:0][7:0] ch_din;
  logic [1:0]      ch_din_valid;
  logic [1:0]      ch_din_ready;
  logic [7:0]      ch_dout;
  logic [1:0]      ch_dout_valid;
  logic [1:0]      grant;

  // shared cipher side
  logic [7:0]      c_key;
  logic            c_key_in;
  logic [7:0]      c_din;
  logic            c_din_valid;
  logic [7:0]      c_dout;
  logic            c_dout_valid;

  modport master (
    input  ch_key, ch_key_in, ch_din, ch_din_valid, c_dout, c_dout_valid,
    output ch_din_ready, ch_dout, ch_dout_valid, grant,
           c_key, c_key_in, c_din, c_din_valid
  );

  modport slave (
    output ch_key, ch_key_in, ch_din, ch_din_valid, c_dout, c_dout_valid,
    input  ch_din_ready, ch_dout, ch_dout_valid, grant,
           c_key, c_key_in, c_din, c_din_valid
  );
endinterface

// File: rtl/stream_cipher_arbiter.sv
// Time-shares one stream_cipher between two byte channels, saving each channel's
// counter block and reloading it into the cipher on every grant.
module stream_cipher_arbiter #(
  parameter int BURST_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stream_cipher_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
  localparam logic [7:0] BURST_LIM  = 8'(BURST_MAX);

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [7:0]      bcnt_q, bcnt_d;
  logic [1:0][7:0] ctr_q, ctr_d;
  logic            iss_q, iss_d;
  logic            own_q, own_d;

  logic            gsel;
  logic [1:0]      req;
  logic [1:0]      ready;
  logic            accept;
  logic [7:0]      c_key;
  logic            c_key_in;
  logic [7:0]      c_din;
  logic            c_din_valid;
  logic            c_dout_valid_unused;

  // grant_q is one-hot whenever it matters, so bit 1 is the owner's index
  assign gsel = grant_q[1];
  assign req  = bus.ch_din_valid & ~bus.ch_key_in;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    bcnt_d      = bcnt_q;
    ready       = 2'b00;
    accept      = 1'b0;
    c_key       = 8'h00;
    c_key_in    = 1'b0;
    c_din       = 8'h00;
    c_din_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = LOAD;
          if (req == 2'b11) begin
            grant_d = last_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = req;
          end
        end
      end

      LOAD: begin
        c_key_in = 1'b1;
        c_key    = ctr_q[gsel];
        bcnt_d   = 8'h00;
        if (bus.ch_key_in[gsel]) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = STREAM;
        end
      end

      STREAM: begin
        ready[gsel] = !bus.ch_key_in[gsel] && (bcnt_q < BURST_LIM);
        accept      = ready[gsel] && bus.ch_din_valid[gsel];
        if (accept) begin
          c_din_valid = 1'b1;
          c_din       = bus.ch_din[gsel];
          bcnt_d      = bcnt_q + 8'h01;
        end
        // a key change ends the burst so the new counter is picked up by LOAD
        if (!bus.ch_din_valid[gsel] || bus.ch_key_in[gsel] ||
            (accept && bcnt_q == BURST_LAST)) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = gsel;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    assign ctr_d[gi] = bus.ch_key_in[gi]               ? bus.ch_key[gi] :
                       (accept && gsel == 1'(gi))      ? ctr_q[gi] + 8'h01 :
                                                         ctr_q[gi];
    assign bus.ch_dout_valid[gi] = iss_q && (own_q == 1'(gi));
  end

  // routing follows our own issue record; the cipher's dout_valid goes stale on key loads
  assign iss_d = accept;
  assign own_d = accept ? gsel : own_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      bcnt_q  <= 8'h00;
      ctr_q   <= '0;
      iss_q   <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      ctr_q   <= ctr_d;
      iss_q   <= iss_d;
      own_q   <= own_d;
    end
  end

  assign c_dout_valid_unused = bus.c_dout_valid;

  assign bus.grant        = grant_q;
  assign bus.ch_din_ready = ready;
  assign bus.ch_dout      = bus.c_dout;
  assign bus.c_key        = c_key;
  assign bus.c_key_in     = c_key_in;
  assign bus.c_din        = c_din;
  assign bus.c_din_valid  = c_din_valid;

endmodule

// File: tb/tb_stream_cipher_arbiter.sv
// Bench for stream_cipher_arbiter: a behavioural cipher with a sticky dout_valid,
// a per-channel counter model and a scoreboard of expected ciphertext bytes.
module tb_stream_cipher_arbiter;

  localparam int BMAX = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  stream_cipher_arbiter_if bus();

  stream_cipher_arbiter #(.BURST_MAX(BMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] ks(input logic [7:0] x);
    logic [7:0] y;
    y = x * 8'd29 + 8'h63;
    return y ^ {y[2:0], y[7:3]};
  endfunction

  // cipher model: dout_valid stays high once set, so stale valid is always present
  logic [7:0] cc_ctr, cc_dout;
  logic       cc_dv;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_ctr  <= 8'h00;
      cc_dout <= 8'h00;
      cc_dv   <= 1'b0;
    end else if (bus.c_key_in) begin
      cc_ctr <= bus.c_key;
    end else if (bus.c_din_valid) begin
      cc_dout <= bus.c_din ^ ks(cc_ctr);
      cc_ctr  <= cc_ctr + 8'h01;
      cc_dv   <= 1'b1;
    end
  end
  assign bus.c_dout       = cc_dout;
  assign bus.c_dout_valid = cc_dv;

  typedef struct {
    logic       ch;
    logic [7:0] data;
  } exp_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         n_acc = 0;
  int         n_pulse = 0;
  int         t_first = -1;
  int         rem [2];
  logic [1:0] acc_flag = 2'b00;
  logic [7:0] m_ctr [2];
  logic [7:0] din_r [2];
  logic       rand_din = 1'b0;
  logic [1:0] kin = 2'b00;
  logic [7:0] kval [2];
  exp_t       sb [$];
  logic [8:0] ld_q [$];
  logic [7:0] dlog [$];
  int         bl_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ld_at(input int k);
    return (k < ld_q.size()) ? {23'b0, ld_q[k]} : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dl_at(input int k);
    return (k < dlog.size()) ? {24'b0, dlog[k]} : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] bl_at(input int k);
    return (k < bl_q.size()) ? bl_q[k] : 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      logic [1:0] acc;
      acc = bus.ch_din_valid & bus.ch_din_ready;
      chk("grant_onehot", 32'($countones(bus.grant) <= 1), 1);
      chk("ready_owner", {30'b0, bus.ch_din_ready & ~bus.grant}, 0);
      chk("c_din_valid", {31'b0, bus.c_din_valid}, {31'b0, |acc});
      if (bus.c_key_in) begin
        chk("load_excl", {31'b0, bus.c_din_valid}, 0);
        chk("load_grant", {31'b0, |bus.grant}, 1);
        chk("load_key", {24'b0, bus.c_key}, {24'b0, m_ctr[bus.grant[1]]});
        ld_q.push_back({bus.grant[1], bus.c_key});
        bl_q.push_back(0);
      end
      for (int i = 0; i < 2; i++) begin
        if (bus.ch_key_in[i] && bus.grant[i])
          chk("keyin_ready", {31'b0, bus.ch_din_ready[i]}, 0);
        if (acc[i]) begin
          chk("c_din", {24'b0, bus.c_din}, {24'b0, bus.ch_din[i]});
          e.ch   = i[0];
          e.data = bus.ch_din[i] ^ ks(m_ctr[i]);
          sb.push_back(e);
          m_ctr[i] = m_ctr[i] + 8'h01;
          n_acc++;
          acc_flag[i] = 1'b1;
          if (bl_q.size() > 0) bl_q[bl_q.size()-1] = bl_q[bl_q.size()-1] + 1;
        end
      end
      if (|bus.ch_dout_valid) begin
        n_pulse++;
        if (t_first < 0) t_first = cyc;
        if (sb.size() == 0) begin
          chk("spurious_dout", {30'b0, bus.ch_dout_valid}, 0);
        end else begin
          e = sb.pop_front();
          chk("dout_owner", {30'b0, bus.ch_dout_valid}, e.ch ? 32'd2 : 32'd1);
          chk("dout_data", {24'b0, bus.ch_dout}, {24'b0, e.data});
          dlog.push_back(bus.ch_dout);
          $display("txn cyc=%0d ch_dout_valid=%b ch_dout=%02h", cyc, bus.ch_dout_valid, bus.ch_dout);
        end
      end
      for (int i = 0; i < 2; i++)
        if (bus.ch_key_in[i]) m_ctr[i] = bus.ch_key[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc_flag[i]) begin
        if (rem[i] > 0) rem[i]--;
        din_r[i] = rand_din ? 8'($urandom) : 8'h00;
      end
      bus.ch_din[i]       = din_r[i];
      bus.ch_din_valid[i] = (rem[i] != 0);
      bus.ch_key[i]       = kval[i];
    end
    acc_flag      = 2'b00;
    bus.ch_key_in = kin;
    kin           = 2'b00;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((rem[0] != 0 || rem[1] != 0 || sb.size() != 0 || bus.grant != 2'b00) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 1);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n;
    n = 0;
    while (n_acc < target && n < budget) begin
      step();
      n++;
    end
    chk("accept_timeout", 32'(n < budget), 1);
  endtask

  task automatic clr_logs();
    ld_q.delete();
    dlog.delete();
    bl_q.delete();
    t_first = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", {bus.grant, bus.ch_din_ready, bus.ch_dout_valid, bus.c_key,
                          bus.c_key_in, bus.c_din, bus.c_din_valid, bus.ch_dout}, 0);
    for (int i = 0; i < 2; i++) begin
      rem[i]   = 0;
      m_ctr[i] = 8'h00;
      din_r[i] = 8'h00;
      kval[i]  = 8'h00;
    end
    bus.ch_din        = '0;
    bus.ch_din_valid  = 2'b00;
    bus.ch_key        = '0;
    bus.ch_key_in     = 2'b00;
    kin      = 2'b00;
    acc_flag = 2'b00;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t_req, base, pre, a0, p0;
    do_reset();

    // basic stream: key 10, four zero bytes on channel 0
    rand_din = 1'b0;
    kin = 2'b01; kval[0] = 8'h10;
    step();
    clr_logs();
    rem[0] = 4;
    step();
    t_req = cyc;
    wait_done(100);
    chk("t1_latency", 32'(t_first - t_req), 3);
    chk("t1_nloads", ld_q.size(), 1);
    chk("t1_key", ld_at(0), 32'h010);
    for (int k = 0; k < 4; k++) chk("t1_dout", dl_at(k), {24'b0, ks(8'(8'h10 + k))});
    clr_logs();
    rem[0] = 1;
    step();
    wait_done(100);
    chk("t1_ctr_end", ld_at(0), 32'h014);

    // counter wrap-around FE, FF, 00 then reload with 01
    kin = 2'b01; kval[0] = 8'hFE;
    step();
    clr_logs();
    rem[0] = 3;
    step();
    wait_done(100);
    chk("t3_d0", dl_at(0), {24'b0, ks(8'hFE)});
    chk("t3_d1", dl_at(1), {24'b0, ks(8'hFF)});
    chk("t3_d2", dl_at(2), {24'b0, ks(8'h00)});
    rem[0] = 1;
    step();
    wait_done(100);
    chk("t3_reload", ld_at(1), 32'h001);
    chk("t3_d3", dl_at(3), {24'b0, ks(8'h01)});

    // key load on the owner mid-burst
    kin = 2'b01; kval[0] = 8'h20;
    step();
    clr_logs();
    base = n_acc;
    rem[0] = 10;
    step();
    wait_acc(base + 4, 50);
    kin = 2'b01; kval[0] = 8'h55;
    step();
    pre = n_acc - base;
    step();
    chk("t4_idle", {30'b0, bus.grant}, 0);
    wait_done(100);
    chk("t4_first_key", ld_at(0), 32'h020);
    chk("t4_new_key", ld_at(1), 32'h055);
    chk("t4_dout_after", dl_at(pre), {24'b0, ks(8'h55)});

    // other-channel key load during a burst, then stale cipher valid on the switch
    kin = 2'b01; kval[0] = 8'h40;
    step();
    clr_logs();
    a0 = n_acc; p0 = n_pulse;
    rem[0] = 5;
    step(); step(); step();
    kin = 2'b10; kval[1] = 8'h33;
    rem[1] = 2;
    step();
    wait_done(100);
    chk("t5_load0", ld_at(0), 32'h040);
    chk("t5_load1", ld_at(1), 32'h133);
    chk("t5_burst0", bl_at(0), 5);
    chk("t5_pulses", 32'(n_pulse - p0), 32'(n_acc - a0));
    chk("t5_accepts", 32'(n_acc - a0), 7);
    chk("t5_ch1_d0", dl_at(5), {24'b0, ks(8'h33)});

    // tie-break and alternation from a fresh reset
    do_reset();
    rand_din = 1'b1;
    kin = 2'b11; kval[0] = 8'h00; kval[1] = 8'h80;
    step();
    clr_logs();
    rem[0] = 32; rem[1] = 32;
    step();
    wait_done(300);
    chk("t2_nloads", ld_q.size(), 4);
    chk("t2_load0", ld_at(0), 32'h000);
    chk("t2_load1", ld_at(1), 32'h180);
    chk("t2_load2", ld_at(2), 32'h010);
    chk("t2_load3", ld_at(3), 32'h190);
    for (int k = 0; k < 4; k++) chk("t2_burst_len", bl_at(k), BMAX);

    // reset in the middle of a burst
    clr_logs();
    base = n_acc;
    rem[0] = 20;
    step();
    wait_acc(base + 5, 50);
    chk("t6_streaming", {30'b0, bus.grant}, 1);
    do_reset();
    clr_logs();
    rem[0] = 2;
    step();
    wait_done(100);
    chk("t6_key", ld_at(0), 32'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
